// File: rtl/rng_health_fifo.sv
// rng_health_fifo: repetition-count health test on incoming random words with
// warm-up discard, alarm latch and a show-ahead valid/ready output FIFO.
module rng_health_fifo #(
    parameter int DATA_WIDTH    = 16,
    parameter int FIFO_DEPTH    = 8,
    parameter int REP_LIMIT     = 4,
    parameter int STARTUP_WORDS = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          in_valid,
    input  logic                          clear_alarm,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          alarm,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    drop_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int RW = $clog2(REP_LIMIT + 1);
    localparam int SW = $clog2(STARTUP_WORDS + 1);
    localparam logic [RW-1:0] REP_MAX    = RW'(REP_LIMIT);
    localparam logic [SW-1:0] START_LAST = SW'(STARTUP_WORDS - 1);
    localparam logic [LW-1:0] DEPTH_L    = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {STARTUP, RUN, ALARM} state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   last_q;
    logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [RW-1:0]           rep_q, rep_d, rep_inc;
    logic [SW-1:0]           start_q, start_d;
    logic [AW-1:0]           rd_q, rd_d, wr_q, wr_d;
    logic [LW-1:0]           cnt_q, cnt_d;
    logic [7:0]              drop_q, drop_d;
    logic                    testing, trip, full, pop, push_req, push, flush;

    always_comb begin
        testing  = in_valid && state_q != ALARM;
        rep_inc  = (in_data == last_q) ? ((rep_q == REP_MAX) ? rep_q : rep_q + 1'b1) : RW'(1);
        trip     = testing && rep_inc == REP_MAX;
        full     = cnt_q == DEPTH_L;
        pop      = out_valid && out_ready;
        push_req = state_q == RUN && in_valid && !trip;
        push     = push_req && (!full || pop);
        flush    = trip || state_q == ALARM;
        state_d  = state_q;
        start_d  = start_q;
        rep_d    = testing ? rep_inc : rep_q;
        if (state_q == ALARM && clear_alarm) begin
            state_d = STARTUP;
            start_d = '0;
            rep_d   = '0;
        end else if (trip) begin
            state_d = ALARM;
        end else if (state_q == STARTUP && in_valid) begin
            start_d = (start_q == START_LAST) ? '0 : start_q + 1'b1;
            state_d = (start_q == START_LAST) ? RUN : STARTUP;
        end
        rd_d   = flush ? '0 : rd_q + AW'(pop);
        wr_d   = flush ? '0 : wr_q + AW'(push);
        cnt_d  = flush ? '0 : cnt_q + LW'(push) - LW'(pop);
        drop_d = (push_req && full && !pop && drop_q != 8'hFF) ? drop_q + 1'b1 : drop_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= STARTUP;
            last_q  <= '0;
            rep_q   <= '0;
            start_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= testing ? in_data : last_q;
            rep_q   <= rep_d;
            start_q <= start_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    // Storage is cleared on reset so the head word reads zero until first use.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_q] <= in_data;
        end
    end

    assign out_data   = mem_q[rd_q];
    assign out_valid  = cnt_q != '0 && state_q == RUN;
    assign alarm      = state_q == ALARM;
    assign fifo_level = cnt_q;
    assign drop_count = drop_q;
endmodule

// File: tb/tb_rng_health_fifo.sv
// tb_rng_health_fifo: scenario tasks with a scoreboard of expected output words.
module tb_rng_health_fifo;
    logic        clk = 0;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        clear_alarm;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        alarm;
    logic [3:0]  fifo_level;
    logic [7:0]  drop_count;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] sb[$];
    logic [15:0] exp_w;

    rng_health_fifo dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .clear_alarm(clear_alarm), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .alarm(alarm), .fifo_level(fifo_level),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // One clock: scoreboard check at the falling edge, then advance past the rising edge.
    task automatic tick();
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL out_word unexpected got=%h with empty scoreboard", out_data);
            end else begin
                exp_w = sb.pop_front();
                if (out_data !== exp_w) begin
                    fails++;
                    $display("FAIL out_word got=%h expected=%h", out_data, exp_w);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] w);
        in_data  = w;
        in_valid = 1;
        tick();
        in_valid = 0;
    endtask

    task automatic startup_burst(input logic [15:0] base);
        for (int i = 0; i < 16; i++) begin
            drive(base + 16'(i));
            tests++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL startup_discard word %0d out_valid=%b expected=0", i, out_valid);
            end
        end
    endtask

    task automatic drain_check(input string name, input int cycles);
        repeat (cycles) tick();
        tests++;
        if (fifo_level !== 4'd0 || sb.size() != 0) begin
            fails++;
            $display("FAIL %s_drain level=%0d pending=%0d expected 0/0", name, fifo_level, sb.size());
        end
    endtask

    task automatic test_reset();
        rst = 1; in_valid = 0; in_data = 0; clear_alarm = 0; out_ready = 0;
        tick(); tick();
        tests++;
        if (out_valid !== 0 || alarm !== 0 || fifo_level !== 0 || drop_count !== 0 || out_data !== 0) begin
            fails++;
            $display("FAIL reset_state v=%b a=%b l=%0d d=%0d q=%h expected all 0",
                     out_valid, alarm, fifo_level, drop_count, out_data);
        end
        rst = 0;
        tick();
    endtask

    task automatic test_startup();
        out_ready = 1;
        startup_burst(16'h0100);
        sb.push_back(16'h1111);
        drive(16'h1111);
        tests++;
        if (out_valid !== 1 || out_data !== 16'h1111) begin
            fails++;
            $display("FAIL first_word v=%b q=%h expected 1/1111", out_valid, out_data);
        end
        sb.push_back(16'h2222);
        drive(16'h2222);
        tests++;
        if (out_valid !== 1 || out_data !== 16'h2222) begin
            fails++;
            $display("FAIL second_word v=%b q=%h expected 1/2222", out_valid, out_data);
        end
        drain_check("startup", 2);
    endtask

    task automatic test_overflow();
        out_ready = 0;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) sb.push_back(16'h2000 + 16'(i));
            drive(16'h2000 + 16'(i));
        end
        tests++;
        if (fifo_level !== 4'd8 || drop_count !== 8'd2) begin
            fails++;
            $display("FAIL overflow level=%0d drop=%0d expected 8/2", fifo_level, drop_count);
        end
        out_ready = 1;
        drain_check("overflow", 8);
    endtask

    task automatic test_back_to_back();
        out_ready = 0;
        for (int i = 0; i < 8; i++) begin
            sb.push_back(16'h5000 + 16'(i));
            drive(16'h5000 + 16'(i));
        end
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(16'h5100 + 16'(i));
            drive(16'h5100 + 16'(i));
            tests++;
            if (fifo_level !== 4'd8 || drop_count !== 8'd2) begin
                fails++;
                $display("FAIL full_push_pop %0d level=%0d drop=%0d expected 8/2", i, fifo_level, drop_count);
            end
        end
        drain_check("back_to_back", 8);
    endtask

    task automatic test_rep_alarm();
        out_ready = 0;
        for (int i = 0; i < 3; i++) drive(16'hAAAA);
        tests++;
        if (fifo_level !== 4'd3 || alarm !== 0) begin
            fails++;
            $display("FAIL rep_three level=%0d alarm=%b expected 3/0", fifo_level, alarm);
        end
        drive(16'hAAAA);
        tests++;
        if (alarm !== 1 || fifo_level !== 0 || out_valid !== 0) begin
            fails++;
            $display("FAIL rep_trip alarm=%b level=%0d v=%b expected 1/0/0", alarm, fifo_level, out_valid);
        end
    endtask

    task automatic test_clear();
        out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            in_data  = 16'h0F00 + 16'(i);
            in_valid = i[0];
            tick();
            tests++;
            if (alarm !== 1 || fifo_level !== 0 || out_valid !== 0) begin
                fails++;
                $display("FAIL alarm_hold %0d alarm=%b level=%0d v=%b expected 1/0/0", i, alarm, fifo_level, out_valid);
            end
        end
        in_valid = 0;
        clear_alarm = 1;
        tick();
        clear_alarm = 0;
        tests++;
        if (alarm !== 0 || drop_count !== 8'd2) begin
            fails++;
            $display("FAIL alarm_clear alarm=%b drop=%0d expected 0/2", alarm, drop_count);
        end
        startup_burst(16'h0300);
        sb.push_back(16'h3333);
        drive(16'h3333);
        tests++;
        if (out_valid !== 1 || out_data !== 16'h3333) begin
            fails++;
            $display("FAIL resume_word v=%b q=%h expected 1/3333", out_valid, out_data);
        end
        drain_check("clear", 2);
    endtask

    task automatic test_drop_saturate();
        out_ready = 0;
        for (int i = 0; i < 268; i++) begin
            if (i < 8) sb.push_back(16'h6000 + 16'(i));
            drive(16'h6000 + 16'(i));
        end
        tests++;
        if (drop_count !== 8'd255 || fifo_level !== 4'd8) begin
            fails++;
            $display("FAIL drop_saturate drop=%0d level=%0d expected 255/8", drop_count, fifo_level);
        end
        out_ready = 1;
        drain_check("saturate", 8);
    endtask

    task automatic test_reset_mid();
        out_ready = 0;
        for (int i = 0; i < 5; i++) drive(16'h7000 + 16'(i));
        tests++;
        if (fifo_level !== 4'd5) begin
            fails++;
            $display("FAIL pre_reset_level level=%0d expected 5", fifo_level);
        end
        rst = 1;
        #1;
        tests++;
        if (out_valid !== 0 || alarm !== 0 || fifo_level !== 0 || drop_count !== 0 || out_data !== 0) begin
            fails++;
            $display("FAIL mid_reset v=%b a=%b l=%0d d=%0d q=%h expected all 0",
                     out_valid, alarm, fifo_level, drop_count, out_data);
        end
        tick();
        rst = 0;
        out_ready = 1;
        startup_burst(16'h0400);
        sb.push_back(16'h4444);
        drive(16'h4444);
        tests++;
        if (out_valid !== 1 || out_data !== 16'h4444) begin
            fails++;
            $display("FAIL post_reset_word v=%b q=%h expected 1/4444", out_valid, out_data);
        end
        drain_check("reset_mid", 2);
    endtask

    initial begin
        test_reset();
        test_startup();
        test_overflow();
        test_back_to_back();
        test_rep_alarm();
        test_clear();
        test_drop_saturate();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
